// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter
//   Round-robin arbiter sharing the single system bus between NUM_MASTERS
//   requesters and one slave. One transaction is outstanding at a time; the
//   granted master receives read data and a one-cycle completion pulse. A slave
//   that never acknowledges is aborted with an error after TIMEOUT_CYCLES
//   BUSY cycles (0 disables the timeout).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   m_req[N]          per-master request, held until m_ack
//   m_we[N]           per-master write enable
//   m_adr[32N]        packed addresses, master i at [32i+31:32i]
//   m_wdata[32N]      packed write data, same packing
//   m_ack[N]          one-hot completion pulse
//   m_err             qualifies m_ack: transaction timed out
//   m_rdata[32]       read data, valid with m_ack
//   s_request         slave request, held for the whole transaction
//   s_we/s_adr/s_wdata slave command, stable while s_request is high
//   s_rdata, s_ack    slave read data and single-cycle completion
module sys_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [32*NUM_MASTERS-1:0] m_adr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic                      m_err,
  output logic [31:0]               m_rdata,
  output logic                      s_request,
  output logic                      s_we,
  output logic [31:0]               s_adr,
  output logic [31:0]               s_wdata,
  input  logic [31:0]               s_rdata,
  input  logic                      s_ack
);

  localparam int unsigned NM    = NUM_MASTERS;
  localparam int          IDX_W = $clog2(NUM_MASTERS);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q;
  logic             we_q;
  logic [31:0]      adr_q, wdata_q, rdata_q;
  logic             err_q;
  logic [TO_W-1:0]  to_cnt_q;

  logic             load, cap_ack, cap_to;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_we;
  logic [31:0]      sel_adr, sel_wdata;

  // Round-robin pick done as two ascending passes (indices >= rr_ptr first,
  // then the wrapped-around ones) instead of a modulo rotation.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_adr   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (!sel_found && m_req[i] && (i >= 32'(rr_ptr_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_we    = m_we[i];
        sel_adr   = m_adr[32*i +: 32];
        sel_wdata = m_wdata[32*i +: 32];
      end
    end
    for (int unsigned i = 0; i < NM; i++) begin
      if (!sel_found && m_req[i] && (i < 32'(rr_ptr_q))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_we    = m_we[i];
        sel_adr   = m_adr[32*i +: 32];
        sel_wdata = m_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    load     = 1'b0;
    cap_ack  = 1'b0;
    cap_to   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // s_ack has priority over a timeout landing in the same cycle
        if (s_ack) begin
          cap_ack = 1'b1;
          state_d = RESP;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          cap_to  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (32'(grant_q) == NM - 1)
          rr_ptr_d = '0;
        else
          rr_ptr_d = grant_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        grant_q <= sel_idx;
        we_q    <= sel_we;
        adr_q   <= sel_adr;
        wdata_q <= sel_wdata;
      end
      if (cap_ack) begin
        rdata_q <= s_rdata;
        err_q   <= 1'b0;
      end else if (cap_to) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if ((state_q == BUSY) && (state_d == BUSY))
        to_cnt_q <= to_cnt_q + TO_W'(1);
      else
        to_cnt_q <= '0;
    end
  end

  // Outputs decode registered state only; no input reaches an output.
  always_comb begin
    m_ack = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if ((state_q == RESP) && (32'(grant_q) == i))
        m_ack[i] = 1'b1;
    end
  end

  assign m_err     = (state_q == RESP) && err_q;
  assign m_rdata   = (state_q == RESP) ? rdata_q : '0;
  assign s_request = (state_q == BUSY);
  assign s_we      = (state_q == BUSY) && we_q;
  assign s_adr     = (state_q == BUSY) ? adr_q : '0;
  assign s_wdata   = (state_q == BUSY) ? wdata_q : '0;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;

  localparam int NM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NM-1:0]      m_req, m_we;
  logic [32*NM-1:0]   m_adr, m_wdata;
  logic [31:0]        s_rdata;
  logic               s_ack;

  logic [NM-1:0] mn_ack, to_ack;
  logic          mn_err, to_err;
  logic [31:0]   mn_rdata, to_rdata;
  logic          mn_sreq, to_sreq;
  logic          mn_swe, to_swe;
  logic [31:0]   mn_sadr, to_sadr;
  logic [31:0]   mn_swdata, to_swdata;

  sys_bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(255), .TO_W(8)) u_main (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_ack(mn_ack), .m_err(mn_err), .m_rdata(mn_rdata),
    .s_request(mn_sreq), .s_we(mn_swe), .s_adr(mn_sadr), .s_wdata(mn_swdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  sys_bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(4), .TO_W(8)) u_to (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_ack(to_ack), .m_err(to_err), .m_rdata(to_rdata),
    .s_request(to_sreq), .s_we(to_swe), .s_adr(to_sadr), .s_wdata(to_swdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  // Both instances see the same stimulus; sel_to picks which one is observed.
  logic          sel_to;
  logic [NM-1:0] ack_v;
  logic          err_v, sreq_v, swe_v;
  logic [31:0]   rdata_v, sadr_v, swdata_v;

  always_comb begin
    ack_v    = sel_to ? to_ack    : mn_ack;
    err_v    = sel_to ? to_err    : mn_err;
    rdata_v  = sel_to ? to_rdata  : mn_rdata;
    sreq_v   = sel_to ? to_sreq   : mn_sreq;
    swe_v    = sel_to ? to_swe    : mn_swe;
    sadr_v   = sel_to ? to_sadr   : mn_sadr;
    swdata_v = sel_to ? to_swdata : mn_swdata;
  end

  typedef struct packed {
    logic [NM-1:0] ack;
    logic          err;
    logic          chk_data;
    logic [31:0]   rdata;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [NM-1:0] ack, input logic err, input logic chk, input logic [31:0] rd);
    exp_t e;
    e.ack = ack; e.err = err; e.chk_data = chk; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample #1 after the edge, score any completion pulse.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (ack_v !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack_v), 32'(0));
      end else begin
        e = sb.pop_front();
        check("sb_ack", 32'(ack_v), 32'(e.ack));
        check("sb_err", 32'(err_v), 32'(e.err));
        if (e.chk_data) check("sb_rdata", rdata_v, e.rdata);
      end
    end
  endtask

  task automatic wait_ack(input int budget, output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while ((ack_v === '0) && (waited < budget));
    check("ack_within_budget", 32'(ack_v !== '0), 32'(1));
  endtask

  task automatic set_master(input int i, input logic we, input logic [31:0] adr, input logic [31:0] wd);
    m_we[i]          = we;
    m_adr[32*i +: 32]   = adr;
    m_wdata[32*i +: 32] = wd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},    32'(ack_v),  32'(0));
    check({tag, "_err"},    32'(err_v),  32'(0));
    check({tag, "_rdata"},  rdata_v,     32'(0));
    check({tag, "_sreq"},   32'(sreq_v), 32'(0));
    check({tag, "_swe"},    32'(swe_v),  32'(0));
    check({tag, "_sadr"},   sadr_v,      32'(0));
    check({tag, "_swdata"}, swdata_v,    32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req = '0; m_we = '0; m_adr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int w;
    sel_to = 1'b0;

    // Reset state of both instances
    do_reset();
    check_all_zero("reset_main");
    sel_to = 1'b1;
    #1;
    check_all_zero("reset_to");
    sel_to = 1'b0;
    #1;

    // Single read, ack in 3rd BUSY cycle
    do_reset();
    set_master(0, 1'b0, 32'h1000_0004, 32'h0);
    m_req = 3'b001;
    push_exp(3'b001, 1'b0, 1'b1, 32'hA5A5_0001);
    for (int c = 1; c <= 3; c++) begin
      step();
      check("rd_sreq", 32'(sreq_v), 32'(1));
      check("rd_sadr", sadr_v, 32'h1000_0004);
      check("rd_swe",  32'(swe_v), 32'(0));
      check("rd_noack", 32'(ack_v), 32'(0));
      if (c == 3) begin
        s_ack = 1'b1;
        s_rdata = 32'hA5A5_0001;
      end
    end
    step();
    check("rd_ack_c4", 32'(ack_v), 32'(3'b001));
    check("rd_rdata",  rdata_v, 32'hA5A5_0001);
    s_ack = 1'b0; s_rdata = '0; m_req = '0;
    step();
    check("rd_sreq_drop", 32'(sreq_v), 32'(0));

    // Round-robin with all masters requesting, immediate ack
    do_reset();
    for (int i = 0; i < NM; i++) set_master(i, 1'b0, 32'h4000_0000 + 32'(i * 4), 32'h0);
    s_ack = 1'b1;
    s_rdata = 32'h1234_5678;
    m_req = 3'b111;
    push_exp(3'b001, 1'b0, 1'b1, 32'h1234_5678);
    push_exp(3'b010, 1'b0, 1'b1, 32'h1234_5678);
    push_exp(3'b100, 1'b0, 1'b1, 32'h1234_5678);
    push_exp(3'b001, 1'b0, 1'b1, 32'h1234_5678);
    push_exp(3'b010, 1'b0, 1'b1, 32'h1234_5678);
    push_exp(3'b100, 1'b0, 1'b1, 32'h1234_5678);
    for (int g = 0; g < 6; g++) begin
      wait_ack(8, w);
      check("rr_gap", 32'(w), (g == 0) ? 32'(2) : 32'(3));
      if (g == 5) m_req = '0;
    end
    s_ack = 1'b0;
    step();
    check("rr_sreq_drop", 32'(sreq_v), 32'(0));

    // Write held for 10 BUSY cycles
    do_reset();
    set_master(2, 1'b1, 32'h2000_0000, 32'hDEAD_BEEF);
    s_rdata = 32'h0BAD_0BAD;
    m_req = 3'b100;
    push_exp(3'b100, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      step();
      check("wr_sreq",   32'(sreq_v), 32'(1));
      check("wr_swe",    32'(swe_v), 32'(1));
      check("wr_sadr",   sadr_v, 32'h2000_0000);
      check("wr_swdata", swdata_v, 32'hDEAD_BEEF);
      check("wr_noack",  32'(ack_v), 32'(0));
      if (c == 10) s_ack = 1'b1;
    end
    step();
    check("wr_ack", 32'(ack_v), 32'(3'b100));
    s_ack = 1'b0; m_req = '0; m_we = '0;
    repeat (3) begin
      step();
      check("wr_single_ack", 32'(ack_v), 32'(0));
    end

    // Timeout (TIMEOUT_CYCLES=4 instance)
    do_reset();
    sel_to = 1'b1;
    #1;
    set_master(0, 1'b0, 32'h3000_0000, 32'h0);
    s_rdata = 32'hFFFF_FFFF;
    m_req = 3'b001;
    push_exp(3'b001, 1'b1, 1'b1, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("to_sreq", 32'(sreq_v), 32'(1));
      check("to_noack", 32'(ack_v), 32'(0));
    end
    step();
    check("to_ack_c5", 32'(ack_v), 32'(3'b001));
    check("to_err", 32'(err_v), 32'(1));
    check("to_rdata", rdata_v, 32'h0);
    m_req = '0;
    step();
    check("to_idle_sreq", 32'(sreq_v), 32'(0));
    set_master(1, 1'b0, 32'h3000_0010, 32'h0);
    s_ack = 1'b1;
    s_rdata = 32'h600D_0001;
    m_req = 3'b010;
    push_exp(3'b010, 1'b0, 1'b1, 32'h600D_0001);
    wait_ack(6, w);
    check("to_next_lat", 32'(w), 32'(2));
    m_req = '0; s_ack = 1'b0;
    step();
    s_rdata = 32'h600D_0002;
    m_req = 3'b001;
    push_exp(3'b001, 1'b0, 1'b1, 32'h600D_0002);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("tie_sreq", 32'(sreq_v), 32'(1));
      if (c == 4) s_ack = 1'b1;
    end
    step();
    check("tie_ack", 32'(ack_v), 32'(3'b001));
    check("tie_err", 32'(err_v), 32'(0));
    m_req = '0; s_ack = 1'b0;
    step();
    sel_to = 1'b0;
    #1;

    // Reset during BUSY; rr_ptr must return to 0
    do_reset();
    set_master(0, 1'b0, 32'h5000_0000, 32'h0);
    set_master(1, 1'b1, 32'h5000_0004, 32'hCAFE_0001);
    set_master(2, 1'b0, 32'h5000_0008, 32'h0);
    s_ack = 1'b1;
    s_rdata = 32'h0;
    m_req = 3'b001;
    push_exp(3'b001, 1'b0, 1'b1, 32'h0);
    wait_ack(6, w);
    m_req = '0; s_ack = 1'b0;
    step();
    m_req = 3'b010;
    step();
    check("rst_busy_sreq", 32'(sreq_v), 32'(1));
    step();
    rst = 1'b1;
    m_req = '0;
    step();
    check_all_zero("rst_mid");
    rst = 1'b0;
    step();
    check("rst_no_ack", 32'(ack_v), 32'(0));
    s_ack = 1'b1;
    s_rdata = 32'h0000_0077;
    m_req = 3'b111;
    push_exp(3'b001, 1'b0, 1'b1, 32'h0000_0077);
    wait_ack(6, w);
    check("rst_rr_lat", 32'(w), 32'(2));
    m_req = '0; s_ack = 1'b0;
    step();

    // Spurious ack in IDLE
    do_reset();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    repeat (3) begin
      step();
      check("sp_noack", 32'(ack_v), 32'(0));
      check("sp_sreq", 32'(sreq_v), 32'(0));
    end
    s_ack = 1'b1;
    s_rdata = 32'h0000_0055;
    m_req = 3'b100;
    push_exp(3'b100, 1'b0, 1'b1, 32'h0000_0055);
    wait_ack(6, w);
    check("sp_lat", 32'(w), 32'(2));
    m_req = '0; s_ack = 1'b0;
    step();
    step();

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
